// File: rtl/usb_host_trans_ctrl.sv
// rtl/usb_host_trans_ctrl.sv - USB host transaction sequencer with retry, result report and hold-off.
// Optional macro USB_HOST_RETRY_EN enables bounded retry on NAK / receive errors.
module usb_host_trans_ctrl #(
    parameter int DONE_DLY  = 16,
    parameter int DLY_W     = 5,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transReq,
    input  logic [1:0] transType,
    input  logic       isoEn,
    input  logic       sendPacketArbiterGnt,
    input  logic       sendPacketRdy,
    input  logic       getPacketRdy,
    input  logic [7:0] RXStatus,
    output logic       sendPacketArbiterReq,
    output logic       sendPacketWEn,
    output logic [3:0] sendPacketPID,
    output logic       getPacketREn,
    output logic       transDone,
    output logic       clearTXReq,
    output logic [1:0] transResult,
    output logic [3:0] retryCnt
);

`ifdef USB_HOST_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    localparam logic [1:0] T_SETUP = 2'd0;
    localparam logic [1:0] T_IN    = 2'd1;
    localparam logic [1:0] T_OUT1  = 2'd3;

    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;

    localparam logic [1:0] R_OK    = 2'b00;
    localparam logic [1:0] R_NAK   = 2'b01;
    localparam logic [1:0] R_STALL = 2'b10;
    localparam logic [1:0] R_ERR   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_TOKEN, S_TOKEN_END, S_DATA, S_DATA_END, S_RX_REQ,
        S_RX_WAIT, S_EVAL, S_ACK, S_ACK_END, S_FIN_WAIT, S_GAP, S_HOLD
    } state_t;

    state_t           state, stateNext;
    logic [1:0]       typeLat, typeNext;
    logic             isoLat, isoNext;
    logic             rxStall, rxErr, rxNak;
    logic             rxStallNext, rxErrNext, rxNakNext;
    logic [DLY_W-1:0] cnt, cntNext;
    logic             arbReqNext, wEnNext, rEnNext, doneNext;
    logic [3:0]       pidNext, retryNext;
    logic [1:0]       resultNext;
    logic             finish;
    logic [1:0]       finClass;
    logic [3:0]       tokenPid;

    // Bits 7:6 (data toggle, ACK) carry no decision in this block.
    wire unusedRxBits = &{1'b0, RXStatus[7:6]};

    always_comb begin
        tokenPid = PID_OUT;
        if (typeLat == T_SETUP)   tokenPid = PID_SETUP;
        else if (typeLat == T_IN) tokenPid = PID_IN;
    end

    always_comb begin
        stateNext   = state;
        typeNext    = typeLat;
        isoNext     = isoLat;
        rxStallNext = rxStall;
        rxErrNext   = rxErr;
        rxNakNext   = rxNak;
        cntNext     = cnt;
        arbReqNext  = sendPacketArbiterReq;
        wEnNext     = 1'b0;
        rEnNext     = 1'b0;
        doneNext    = 1'b0;
        pidNext     = sendPacketPID;
        resultNext  = transResult;
        retryNext   = retryCnt;
        finish      = 1'b0;
        finClass    = R_OK;

        case (state)
            S_IDLE: if (transReq) begin
                arbReqNext = 1'b1;
                stateNext  = S_ARB;
            end
            S_ARB: if (sendPacketArbiterGnt) begin
                typeNext  = transType;
                isoNext   = isoEn;
                retryNext = 4'd0;
                stateNext = S_TOKEN;
            end
            S_TOKEN: if (sendPacketRdy) begin
                wEnNext   = 1'b1;
                pidNext   = tokenPid;
                stateNext = S_TOKEN_END;
            end
            S_TOKEN_END: stateNext = (typeLat == T_IN) ? S_RX_REQ : S_DATA;
            S_DATA: if (sendPacketRdy) begin
                wEnNext   = 1'b1;
                pidNext   = (typeLat == T_OUT1) ? PID_DATA1 : PID_DATA0;
                stateNext = S_DATA_END;
            end
            S_DATA_END: stateNext = isoLat ? S_FIN_WAIT : S_RX_REQ;
            S_RX_REQ: if (sendPacketRdy) begin
                rEnNext   = 1'b1;
                stateNext = S_RX_WAIT;
            end
            S_RX_WAIT: if (getPacketRdy) begin
                rxStallNext = RXStatus[4];
                rxErrNext   = RXStatus[0] | RXStatus[1] | RXStatus[2] | RXStatus[5];
                rxNakNext   = RXStatus[3];
                stateNext   = S_EVAL;
            end
            S_EVAL: begin
                if (typeLat == T_IN && isoLat) begin
                    finish = 1'b1;
                end else if (rxStall) begin
                    finish   = 1'b1;
                    finClass = R_STALL;
                end else if (rxErr || rxNak) begin
                    if (RETRY_ON && !isoLat && int'(retryCnt) < MAX_RETRY) begin
                        retryNext = retryCnt + 4'd1;
                        cntNext   = DLY_W'(RETRY_GAP);
                        stateNext = S_GAP;
                    end else begin
                        finish   = 1'b1;
                        finClass = rxErr ? R_ERR : R_NAK;
                    end
                end else if (typeLat == T_IN) begin
                    stateNext = S_ACK;
                end else begin
                    finish = 1'b1;
                end
            end
            S_ACK: if (sendPacketRdy) begin
                wEnNext   = 1'b1;
                pidNext   = PID_ACK;
                stateNext = S_ACK_END;
            end
            S_ACK_END: stateNext = S_FIN_WAIT;
            S_FIN_WAIT: if (sendPacketRdy) finish = 1'b1;
            S_GAP: begin
                cntNext = cnt - DLY_W'(1);
                if (cnt <= DLY_W'(1)) stateNext = S_TOKEN;
            end
            S_HOLD: begin
                cntNext = cnt - DLY_W'(1);
                if (cnt <= DLY_W'(1)) stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase

        // Completion: the done pulse and request drop share one cycle.
        if (finish) begin
            doneNext   = 1'b1;
            arbReqNext = 1'b0;
            resultNext = finClass;
            cntNext    = DLY_W'(DONE_DLY);
            stateNext  = S_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= S_IDLE;
            typeLat              <= 2'd0;
            isoLat               <= 1'b0;
            rxStall              <= 1'b0;
            rxErr                <= 1'b0;
            rxNak                <= 1'b0;
            cnt                  <= '0;
            sendPacketArbiterReq <= 1'b0;
            sendPacketWEn        <= 1'b0;
            sendPacketPID        <= 4'd0;
            getPacketREn         <= 1'b0;
            transDone            <= 1'b0;
            clearTXReq           <= 1'b0;
            transResult          <= 2'd0;
            retryCnt             <= 4'd0;
        end else begin
            state                <= stateNext;
            typeLat              <= typeNext;
            isoLat               <= isoNext;
            rxStall              <= rxStallNext;
            rxErr                <= rxErrNext;
            rxNak                <= rxNakNext;
            cnt                  <= cntNext;
            sendPacketArbiterReq <= arbReqNext;
            sendPacketWEn        <= wEnNext;
            sendPacketPID        <= pidNext;
            getPacketREn         <= rEnNext;
            transDone            <= doneNext;
            clearTXReq           <= doneNext;
            transResult          <= resultNext;
            retryCnt             <= retryNext;
        end
    end

endmodule

// File: tb/tb_usb_host_trans_ctrl.sv
// tb/tb_usb_host_trans_ctrl.sv - self-checking bench for usb_host_trans_ctrl with packet-engine model.
module tb_usb_host_trans_ctrl;

    localparam int DONE_DLY  = 16;
    localparam int DLY_W     = 5;
    localparam int MAX_RETRY = 3;
    localparam int RETRY_GAP = 8;
`ifdef USB_HOST_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       transReq;
    logic [1:0] transType;
    logic       isoEn;
    logic       sendPacketArbiterGnt;
    logic       sendPacketRdy;
    logic       getPacketRdy;
    logic [7:0] RXStatus;
    logic       sendPacketArbiterReq;
    logic       sendPacketWEn;
    logic [3:0] sendPacketPID;
    logic       getPacketREn;
    logic       transDone;
    logic       clearTXReq;
    logic [1:0] transResult;
    logic [3:0] retryCnt;

    usb_host_trans_ctrl #(
        .DONE_DLY(DONE_DLY), .DLY_W(DLY_W), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
    ) dut (
        .clk(clk), .rst(rst), .transReq(transReq), .transType(transType), .isoEn(isoEn),
        .sendPacketArbiterGnt(sendPacketArbiterGnt), .sendPacketRdy(sendPacketRdy),
        .getPacketRdy(getPacketRdy), .RXStatus(RXStatus),
        .sendPacketArbiterReq(sendPacketArbiterReq), .sendPacketWEn(sendPacketWEn),
        .sendPacketPID(sendPacketPID), .getPacketREn(getPacketREn), .transDone(transDone),
        .clearTXReq(clearTXReq), .transResult(transResult), .retryCnt(retryCnt)
    );

    always #5 clk = ~clk;

    int         nTests = 0;
    int         nFail  = 0;
    int         cycle  = 0;
    bit         gntEn  = 1'b1;
    int         sendBusy = 0;
    int         rxDelay  = 0;
    logic [7:0] rxQ[$];
    logic [7:0] stQ[$];
    logic [3:0] pidLog[$];
    logic [3:0] expPids[$];
    int         tokCyc[$];
    int         rdyCyc[$];
    logic [1:0] expRes;
    int         expRetries;
    logic [7:0] pool[8] = '{8'h80, 8'h08, 8'h01, 8'h02, 8'h04, 8'h20, 8'h10, 8'h09};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send/receive engines and arbiter: rdy drops after each strobe, rx finishes after a random delay.
    initial begin
        sendPacketRdy = 1'b1; getPacketRdy = 1'b0; RXStatus = 8'h00; sendPacketArbiterGnt = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst !== 1'b1) begin
                sendPacketRdy = 1'b1; getPacketRdy = 1'b0; sendPacketArbiterGnt = 1'b0;
                sendBusy = 0; rxDelay = 0;
            end else begin
                sendPacketArbiterGnt = gntEn && sendPacketArbiterReq;
                getPacketRdy = 1'b0;
                if (sendPacketWEn) begin
                    pidLog.push_back(sendPacketPID);
                    if (sendPacketPID == 4'hD || sendPacketPID == 4'h9 || sendPacketPID == 4'h1)
                        tokCyc.push_back(cycle);
                    sendPacketRdy = 1'b0;
                    sendBusy = $urandom_range(1, 3);
                end else if (sendBusy > 0) begin
                    sendBusy--;
                    if (sendBusy == 0) sendPacketRdy = 1'b1;
                end
                if (getPacketREn) begin
                    rxDelay = $urandom_range(1, 4);
                end else if (rxDelay > 0) begin
                    rxDelay--;
                    if (rxDelay == 0) begin
                        getPacketRdy = 1'b1;
                        RXStatus = (rxQ.size() > 0) ? rxQ.pop_front() : 8'h80;
                        rdyCyc.push_back(cycle);
                    end
                end
            end
        end
    end

    // Reference: packet sequence, result class and retry count from the transaction rules.
    task automatic model(input logic [1:0] t, input bit iso);
        bit         fin = 1'b0;
        logic [7:0] s;
        expPids = {}; expRetries = 0; expRes = 2'b00;
        while (!fin) begin
            expPids.push_back(t == 2'd0 ? 4'hD : (t == 2'd1 ? 4'h9 : 4'h1));
            if (t != 2'd1) expPids.push_back(t == 2'd3 ? 4'hB : 4'h3);
            if (iso) begin
                fin = 1'b1;
            end else begin
                s = (expRetries < stQ.size()) ? stQ[expRetries] : 8'h80;
                if (s[4])                            expRes = 2'b10;
                else if (s[0] | s[1] | s[2] | s[5])  expRes = 2'b11;
                else if (s[3])                       expRes = 2'b01;
                else                                 expRes = 2'b00;
                if (expRes == 2'b00) begin
                    if (t == 2'd1) expPids.push_back(4'h2);
                    fin = 1'b1;
                end else if (expRes == 2'b10) begin
                    fin = 1'b1;
                end else if (RETRY_ON && expRetries < MAX_RETRY) begin
                    expRetries++;
                end else begin
                    fin = 1'b1;
                end
            end
        end
    endtask

    task automatic run_trans(input string tag, input logic [1:0] t, input bit iso, input bit holdTest);
        bit got = 1'b0;
        bit done = 1'b0;
        bit rose = 1'b0;
        int n = 0;
        int gap;
        model(t, iso);
        rxQ = stQ; pidLog = {}; tokCyc = {}; rdyCyc = {};
        transType = t; isoEn = iso; transReq = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (sendPacketWEn) got = 1'b1;
        end
        check({tag, ".start"}, got, 1);
        transType = 2'($urandom); isoEn = 1'($urandom);
        for (int i = 0; i < 5000 && !done; i++) begin
            if (!transDone) @(negedge clk);
            if (transDone) done = 1'b1;
        end
        check({tag, ".done"}, done, 1);
        if (done) begin
            check({tag, ".reqDrop"}, sendPacketArbiterReq, 0);
            check({tag, ".clrTX"}, clearTXReq, 1);
            check({tag, ".result"}, transResult, expRes);
            check({tag, ".retryCnt"}, retryCnt, expRetries);
            check({tag, ".pidCount"}, pidLog.size(), expPids.size());
            for (int i = 0; i < pidLog.size() && i < expPids.size(); i++)
                check($sformatf("%s.pid%0d", tag, i), pidLog[i], expPids[i]);
            for (int i = 1; i < tokCyc.size() && i <= rdyCyc.size(); i++) begin
                gap = tokCyc[i] - rdyCyc[i-1];
                check($sformatf("%s.gapMin%0d", tag, i), gap >= RETRY_GAP + 1, 1);
                check($sformatf("%s.gapMax%0d", tag, i), gap <= RETRY_GAP + 4, 1);
            end
        end
        if (holdTest) gntEn = 1'b0;
        else          transReq = 1'b0;
        @(negedge clk);
        check({tag, ".donePulse"}, transDone, 0);
        check({tag, ".resultHeld"}, transResult, expRes);
        if (holdTest) begin
            for (int i = 2; i <= DONE_DLY + 10 && !rose; i++) begin
                @(negedge clk);
                if (sendPacketArbiterReq) begin rose = 1'b1; n = i; end
            end
            check({tag, ".holdRose"}, rose, 1);
            check({tag, ".holdMin"}, n > DONE_DLY, 1);
            check({tag, ".holdMax"}, n <= DONE_DLY + 2, 1);
            transReq = 1'b0;
            rst = 1'b0;
            #1;
            check({tag, ".holdRst"}, {sendPacketArbiterReq, transDone, retryCnt}, 0);
            @(negedge clk);
            rst = 1'b1; gntEn = 1'b1;
            @(negedge clk);
        end else begin
            repeat (DONE_DLY + 4) @(negedge clk);
        end
    endtask

    initial begin
        bit found = 1'b0;
        logic [1:0] rt;
        bit         riso;
        rst = 1'b0; transReq = 1'b0; transType = 2'd0; isoEn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.outputs", {sendPacketArbiterReq, sendPacketWEn, sendPacketPID, getPacketREn,
                                transDone, clearTXReq, transResult, retryCnt}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        stQ = {8'h80};                      run_trans("setup",   2'd0, 1'b0, 1'b1);
        stQ = {8'h00};                      run_trans("in",      2'd1, 1'b0, 1'b0);
        stQ = {8'h00};                      run_trans("inIso",   2'd1, 1'b1, 1'b0);
        stQ = {8'h08, 8'h08, 8'h08, 8'h80}; run_trans("out1Nak", 2'd3, 1'b0, 1'b0);
        stQ = {8'h01, 8'h01, 8'h01, 8'h01}; run_trans("out0Crc", 2'd2, 1'b0, 1'b0);
        stQ = {8'h10};                      run_trans("inStall", 2'd1, 1'b0, 1'b0);
        stQ = {8'h09};                      run_trans("out0Both", 2'd2, 1'b0, 1'b0);
        stQ = {};                           run_trans("out1Iso", 2'd3, 1'b1, 1'b0);

        stQ = {8'h80}; rxQ = stQ; pidLog = {};
        transType = 2'd2; isoEn = 1'b0; transReq = 1'b1;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (sendPacketWEn && sendPacketPID == 4'h3) found = 1'b1;
        end
        check("rstMid.reached", found, 1);
        #1 rst = 1'b0;
        #1 check("rstMid.outputs", {sendPacketArbiterReq, sendPacketWEn, sendPacketPID, getPacketREn,
                                    transDone, clearTXReq, transResult, retryCnt}, 0);
        transReq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        stQ = {8'h80}; run_trans("afterRst", 2'd2, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            rt = 2'($urandom_range(0, 3));
            riso = ($urandom_range(0, 3) == 0);
            stQ = {};
            for (int j = 0; j <= MAX_RETRY; j++)
                stQ.push_back(($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)]);
            run_trans($sformatf("rnd%0d", k), rt, riso, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_host_trans_ctrl.md
# usb_host_trans_ctrl

Parametrised USB host transaction controller. It sequences SETUP, IN, OUT-DATA0 and OUT-DATA1 transactions through the send-packet and get-packet engines under the send-packet arbiter. Over the previous generation it adds:
- bounded automatic retry on NAK and receive errors;
- a reported transaction result;
- a configurable post-transaction hold-off.

It sits between the host slave register interface (transReq/transType/isoEn) and the packet send/receive engines.

## Interface
- DONE_DLY, 16: hold-off cycles after transDone before transReq is sampled again (≥1).
- DLY_W, 5: width of hold-off and retry-gap counter; must hold max(DONE_DLY, RETRY_GAP).
- MAX_RETRY, 3: retries after the first attempt (0–15).
- RETRY_GAP, 8: idle cycles between a failed attempt and its retry (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- transReq  in  1  transaction request, level.
- transType  in  2  0 SETUP, 1 IN, 2 OUTDATA0, 3 OUTDATA1; sampled on arbiter grant.
- isoEn  in  1  isochronous: no handshake phase, no retry; sampled on grant.
- sendPacketArbiterGnt  in  1  arbiter grant.
- sendPacketRdy  in  1  send engine idle / previous packet finished.
- getPacketRdy  in  1  receive engine finished.
- RXStatus  in  8  [0] CRC err, [1] bit-stuff err, [2] overflow, [3] NAK, [4] STALL, [5] timeout, [6] DATA sequence bit, [7] ACK.
- sendPacketArbiterReq  out  1  arbiter request.
- sendPacketWEn  out  1  one-cycle send strobe.
- sendPacketPID  out  4  PID to send; held between strobes.
- getPacketREn  out  1  one-cycle receive strobe.
- transDone  out  1  one-cycle completion pulse.
- clearTXReq  out  1  one-cycle pulse, coincident with transDone.
- transResult  out  2  00 OK, 01 NAK exhausted, 10 STALL, 11 error exhausted; valid from transDone until next transDone.
- retryCnt  out  4  retries used by the current/last transaction.

## Operation
- All outputs are registered. Reset value of every output is 0.
- **IDLE:** on transReq=1, set sendPacketArbiterReq=1 and go to ARB.
- **ARB:** on grant, latch transType and isoEn, clear retryCnt, go to TOKEN.
- **Send step:** wait for sendPacketRdy=1, then assert sendPacketWEn for one cycle with the PID. The following cycle deasserts WEn.
- **Receive step:** wait for sendPacketRdy=1, then pulse getPacketREn for one cycle. Wait for getPacketRdy=1, then evaluate RXStatus in the next cycle.
- **TOKEN PID:** SETUP 0xD, IN 0x9, OUT 0x1.
- **SETUP:** send token, send DATA0 (0x3), receive handshake.
- **OUTDATA0 / OUTDATA1:** send token, send DATA0 (0x3) / DATA1 (0xB), receive handshake. If iso, complete after the data packet, once sendPacketRdy=1.
- **IN:** send token, receive data.
  - If iso, complete with OK.
  - Otherwise, if RXStatus[5:0]==0, send ACK (0x2), wait for sendPacketRdy, complete OK.
- **Evaluation priority:**
  1. STALL → result 10, no retry.
  2. Error, i.e. any of [0],[1],[2],[5] → retryable class 11.
  3. NAK → retryable class 01.
  4. Otherwise OK.
- **Retry:** a retryable outcome with retryCnt<MAX_RETRY and !iso increments retryCnt, waits RETRY_GAP cycles, then restarts at TOKEN. The arbiter request stays high throughout. Otherwise the transaction completes with that class.
- **DONE:** pulse transDone and clearTXReq, drop sendPacketArbiterReq, load the counter. Go to HOLD.
- **HOLD:** count DONE_DLY cycles, then go to IDLE. transReq is ignored in HOLD.

## Timing
- transReq→sendPacketArbiterReq: 1 cycle.
- Grant→first sendPacketWEn: ≥1 cycle; equals 1 when sendPacketRdy is already high.
- getPacketRdy→evaluation result visible: 1 cycle.
- Simultaneous NAK and error bits: error class wins.
- transType/isoEn changes after grant are ignored until the next transaction.
- Reset mid-transaction: immediate return to IDLE; all outputs 0, retryCnt 0, request dropped.
- Counter reload uses DLY_W bits and does not wrap.

## Configuration
- USB_HOST_RETRY_EN defined: retry logic as above.
- Not defined:
  - every retryable outcome completes immediately with its class;
  - retryCnt is tied to 0;
  - RETRY_GAP is unused.

## Test plan
- SETUP, handshake RXStatus=0x80 → PIDs 0xD, 0x3 in order; transResult=00; transDone pulse; arbiter request drops the same cycle; IDLE after 16 hold-off cycles.
- IN with RXStatus=0x00, isoEn=0 → PIDs 0x9 then 0x2; result 00. Same with isoEn=1 → no 0x2 sent.
- OUTDATA1 with handshake NAK (0x08) three times, then ACK (0x80) → 3 retries, each 8 idle cycles after evaluation; PIDs 0x1/0xB repeated; retryCnt=3; result 00.
- OUTDATA0 with CRC error on every attempt, MAX_RETRY=3 → 4 attempts, then result 11, retryCnt=3. With macro undefined → 1 attempt, result 11, retryCnt=0.
- IN with STALL (0x10) → no retry, no ACK sent, result 10.
- rst low during the data phase of OUTDATA0 → all outputs 0 asynchronously; a new transReq after release completes normally.
